// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared PS/2 scan-code constants and receiver types for the key/direction path.
// Imported by the receiver and by the downstream controller's key matching.
package ps2_keyboard_rx_pkg;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_clk_filter.sv
// Two-flop synchroniser plus run-length glitch filter for the PS/2 clock line.
// Emits a single-cycle pulse when the filtered level goes from 1 to 0.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_fall
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with the filtered level;
    // the FILTER_LEN-th disagreeing sample flips the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_fall <= 1'b0;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_level <= r_sync;
                r_fall  <= ~r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_fall = r_fall;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver with break/extended stripping.
// Presents each plain make code on key with a one-cycle key_pressed strobe.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_pressed,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          w_fall;
    logic          r_data_meta;
    logic          r_data_sync;
    rx_state_t     r_state;
    rx_state_t     w_state_next;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_parity;
    logic [TW-1:0] r_tcnt;
    logic          r_brk;
    logic          r_ext;
    logic [7:0]    r_key;
    logic          r_key_pressed;
    logic          r_frame_err;
    logic          w_timeout;
    logic          w_deliver;
    logic          w_err;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .i_raw (ps2_clk),
        .o_fall(w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_deliver    = 1'b0;
        w_err        = 1'b0;
        w_timeout    = (r_state != ST_IDLE) && !w_fall && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
        if (w_timeout) begin
            w_err        = 1'b1;
            w_state_next = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_data_sync) w_state_next = ST_DATA;
                    else              w_err        = 1'b1;
                end
                ST_DATA: begin
                    if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
                end
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP: begin
                    w_state_next = ST_IDLE;
                    if (r_data_sync && odd_parity_ok(r_shift, r_parity)) w_deliver = 1'b1;
                    else                                                 w_err     = 1'b1;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Frame datapath, timeout counter and prefix decoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_meta   <= 1'b1;
            r_data_sync   <= 1'b1;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_parity      <= 1'b0;
            r_tcnt        <= '0;
            r_brk         <= 1'b0;
            r_ext         <= 1'b0;
            r_key         <= 8'h00;
            r_key_pressed <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_data_meta   <= ps2_data;
            r_data_sync   <= r_data_meta;
            r_key_pressed <= 1'b0;
            r_frame_err   <= w_err;

            if (w_fall || r_state == ST_IDLE) r_tcnt <= '0;
            else                              r_tcnt <= r_tcnt + 1'b1;

            if (w_fall) begin
                case (r_state)
                    ST_IDLE: r_bit_cnt <= '0;
                    ST_DATA: begin
                        r_shift   <= {r_data_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    ST_PARITY: r_parity <= r_data_sync;
                    default: ;
                endcase
            end

            // Any byte following a prefix is swallowed, so extended codes never alias single-byte keys.
            if (w_deliver) begin
                if (r_shift == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == PS2_BREAK) begin
                    r_brk <= 1'b1;
                end else if (r_brk || r_ext) begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end else begin
                    r_key         <= r_shift;
                    r_key_pressed <= 1'b1;
                end
            end
        end
    end

    assign key         = r_key;
    assign key_pressed = r_key_pressed;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: framed bytes, prefixes, errors, timeout, reset and glitch.
module tb_ps2_keyboard_rx;

    localparam int HALF    = 30;
    localparam int GAP     = 40;
    localparam int TIMEOUT = 500;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key;
    logic       key_pressed;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int n_kp_cyc = 0;
    int n_err    = 0;
    int n_both   = 0;
    int s_strobe, s_kp_cyc, s_err;
    logic kp_prev = 1'b0;

    ps2_keyboard_rx #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key        (key),
        .key_pressed(key_pressed),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (key_pressed) n_kp_cyc++;
            if (key_pressed && !kp_prev) n_strobe++;
            if (frame_err) n_err++;
            if (key_pressed && frame_err) n_both++;
        end
        kp_prev = key_pressed;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic snap();
        s_strobe = n_strobe;
        s_kp_cyc = n_kp_cyc;
        s_err    = n_err;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(bad_par ? ^d : ~^d);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (GAP) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("reset key", int'(key), 8'h00);
        check_val("reset key_pressed", int'(key_pressed), 0);
        check_val("reset frame_err", int'(frame_err), 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        snap();
        send_frame(8'h1D, 1'b0);
        check_val("1D key", int'(key), 8'h1D);
        check_val("1D strobes", n_strobe - s_strobe, 1);
        check_val("1D strobe width", n_kp_cyc - s_kp_cyc, 1);
        check_val("1D frame_err", n_err - s_err, 0);

        send_frame(8'h23, 1'b0);
        check_val("23 key", int'(key), 8'h23);
        snap();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        check_val("break strobes", n_strobe - s_strobe, 0);
        check_val("break key held", int'(key), 8'h23);

        snap();
        send_frame(8'h29, 1'b1);
        check_val("bad parity err", n_err - s_err, 1);
        check_val("bad parity strobes", n_strobe - s_strobe, 0);
        check_val("bad parity key", int'(key), 8'h23);
        snap();
        send_frame(8'h29, 1'b0);
        check_val("29 key", int'(key), 8'h29);
        check_val("29 strobes", n_strobe - s_strobe, 1);

        snap();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'h5A, 1'b0);
        check_val("ext strobes", n_strobe - s_strobe, 1);
        check_val("ext key", int'(key), 8'h5A);
        check_val("ext frame_err", n_err - s_err, 0);

        snap();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TIMEOUT + 200) @(posedge clk);
        @(negedge clk);
        check_val("timeout err", n_err - s_err, 1);
        check_val("timeout strobes", n_strobe - s_strobe, 0);
        snap();
        send_frame(8'h1C, 1'b0);
        check_val("1C key", int'(key), 8'h1C);
        check_val("1C strobes", n_strobe - s_strobe, 1);
        check_val("1C frame_err", n_err - s_err, 0);

        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("mid-frame rst key", int'(key), 8'h00);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        snap();
        ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (GAP) @(posedge clk);
        @(negedge clk);
        check_val("glitch err", n_err - s_err, 0);
        send_frame(8'h1B, 1'b0);
        check_val("1B key", int'(key), 8'h1B);
        check_val("1B strobes", n_strobe - s_strobe, 1);
        check_val("1B frame_err", n_err - s_err, 0);

        snap();
        send_frame(8'h1B, 1'b0);
        check_val("typematic strobes", n_strobe - s_strobe, 1);
        check_val("strobe/err overlap", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
